// File: rtl/jk_cmd_sequencer.sv
// Purpose: queues J-K flip-flop operations, drives J/K one op per clock, models Q and flags mismatches.
// Latency: a command accepted at edge t appears on J/K after edge t+1 (idle engine); queued commands follow with no bubble.
// Backpressure: cmd_ready = !full; a pop that frees a full FIFO raises cmd_ready on the next edge.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             err_clr,
    input  logic             q_in,
    output logic             J,
    output logic             K,
    output logic             exp_q,
    output logic             busy,
    output logic             mismatch,
    output logic [7:0]       err_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_DRIVE = 1'b1;

    // Command storage
    logic [1:0]       op_mem  [DEPTH];
    logic [CNT_W-1:0] len_mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;

    logic             state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             j_q,      j_d;
    logic             k_q,      k_d;

    logic             exp_q_q,    exp_q_d;
    logic             armed_q,    armed_d;
    logic             mismatch_q, mismatch_d;
    logic [7:0]       err_cnt_q,  err_cnt_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             load;
    logic             mis_now;
    logic [1:0]       head_op;
    logic [CNT_W-1:0] head_len;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign push     = cmd_valid && !full;
    assign head_op  = op_mem[rd_ptr_q];
    assign head_len = len_mem[rd_ptr_q];

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Engine: pops a command when idle or when the current one finishes, so commands run back to back
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        k_d     = k_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                j_d = 1'b0;
                k_d = 1'b0;
                if (!empty) begin
                    load = 1'b1;
                end
            end
            default: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!empty) begin
                    load = 1'b1;
                end else begin
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
        if (load) begin
            j_d     = head_op[1];
            k_d     = head_op[0];
            // A zero length still occupies one cycle
            cnt_d   = (head_len == '0) ? '0 : head_len - CNT_W'(1);
            state_d = S_DRIVE;
        end
    end

    assign pop = load;

    // Reference model and checker: exp_q follows the J/K currently driven, errors are sticky
    always_comb begin
        exp_q_d    = exp_q_q;
        mismatch_d = mismatch_q;
        err_cnt_d  = err_cnt_q;
        mis_now    = armed_q && (q_in != exp_q_q);
        armed_d    = armed_q | load;
        case ({j_q, k_q})
            2'b01:   exp_q_d = 1'b0;
            2'b10:   exp_q_d = 1'b1;
            2'b11:   exp_q_d = ~exp_q_q;
            default: exp_q_d = exp_q_q;
        endcase
        if (err_clr) begin
            // A fresh mismatch in the clearing cycle is kept as the first new error
            mismatch_d = mis_now;
            err_cnt_d  = mis_now ? 8'd1 : 8'd0;
        end else if (mis_now) begin
            mismatch_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // Control and checker state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            exp_q_q    <= 1'b0;
            armed_q    <= 1'b0;
            mismatch_q <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            j_q        <= j_d;
            k_q        <= k_d;
            exp_q_q    <= exp_q_d;
            armed_q    <= armed_d;
            mismatch_q <= mismatch_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Command storage write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_mem[i]  <= 2'b00;
                len_mem[i] <= '0;
            end
        end else if (push) begin
            op_mem[wr_ptr_q]  <= cmd_op;
            len_mem[wr_ptr_q] <= cmd_len;
        end
    end

    assign cmd_ready = !full;
    assign J         = j_q;
    assign K         = k_q;
    assign exp_q     = exp_q_q;
    assign busy      = !empty || (state_q == S_DRIVE);
    assign mismatch  = mismatch_q;
    assign err_count = err_cnt_q;

endmodule
